// File: rtl/button_input_pkg.sv
// Shared types and helpers for the pushbutton front end.
package button_input_pkg;

  // Colour FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_REL_DB   = 2'd3
  } btn_state_t;

  // Default debounce length in clock cycles
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;

  // True when exactly one of the four colour bits is set
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

  // Index of the set bit of a one-hot colour vector
  function automatic logic [1:0] encode4(input logic [3:0] v);
    logic [1:0] code;
    code = 2'd0;
    unique case (v)
      4'b0010: code = 2'd1;
      4'b0100: code = 2'd2;
      4'b1000: code = 2'd3;
      default: code = 2'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/button_input_debounce_bit.sv
// Single-bit two-flop synchronizer plus debounce counter and stable level.
module debounce_bit
  import button_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic din,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
    end
  end

  // Flip the level after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_2 != level) begin
      if (cnt == CNT_LAST) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/button_input.sv
// Colour/start pushbutton front end: synchronize, debounce, encode.
module button_input
  import button_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  input  logic       BTN_START,
  output logic [1:0] OUT,
  output logic       OUT_VALID,
  output logic       START_GAME
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync_1;
  logic [3:0]       s;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cand;
  logic [3:0]       cand_vec;

  assign cand_vec = 4'b0001 << cand;

  // Two-flop synchronizers for the colour vector
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_1 <= '0;
      s      <= '0;
    end else begin
      sync_1 <= BTN;
      s      <= sync_1;
    end
  end

  // Colour FSM: debounce a single press, hold valid until debounced release
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cand      <= '0;
      OUT       <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_onehot4(s)) begin
            cand  <= encode4(s);
            cnt   <= CNT_W'(1);
            state <= ST_PRESS_DB;
          end
        end
        ST_PRESS_DB: begin
          if (s == cand_vec) begin
            if (cnt == CNT_LAST) begin
              OUT       <= cand;
              OUT_VALID <= 1'b1;
              cnt       <= '0;
              state     <= ST_PRESSED;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (s == '0) begin
            cnt   <= CNT_W'(1);
            state <= ST_REL_DB;
          end
        end
        ST_REL_DB: begin
          if (s == '0) begin
            if (cnt == CNT_LAST) begin
              OUT_VALID <= 1'b0;
              cnt       <= '0;
              state     <= ST_IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            cnt   <= '0;
            state <= ST_PRESSED;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  debounce_bit #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_start_db (
    .CLK  (CLK),
    .RST_N(RST_N),
    .din  (BTN_START),
    .level(START_GAME)
  );

endmodule

// File: tb/tb_button_input.sv
// Directed bench for button_input with DEBOUNCE_CYCLES=4.
module tb_button_input;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] BTN;
  logic       BTN_START;
  logic [1:0] OUT;
  logic       OUT_VALID;
  logic       START_GAME;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [3:0] exp_q[$];
  string      tag_q[$];

  button_input #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .BTN       (BTN),
    .BTN_START (BTN_START),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .START_GAME(START_GAME)
  );

  always #5 CLK = ~CLK;

  // Advance n active edges, landing 1 ns after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Pop the oldest expectation and compare against the outputs
  task automatic check();
    logic [3:0] e;
    logic [3:0] obs;
    string      t;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed no expectation, expected one queued");
      return;
    end
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    obs = {OUT_VALID, OUT, START_GAME};
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed valid=%b out=%0d start=%b, expected valid=%b out=%0d start=%b",
             t, obs[3], obs[2:1], obs[0], e[3], e[2:1], e[0]);
    end
  endtask

  // Queue an expectation, run n edges, then compare
  task automatic expect_after(input int n, input string tag, input logic v,
                              input logic [1:0] o, input logic st);
    exp_q.push_back({v, o, st});
    tag_q.push_back(tag);
    step(n);
    check();
  endtask

  initial begin
    RST_N     = 1'b0;
    BTN       = '0;
    BTN_START = 1'b0;
    step(2);
    expect_after(0, "reset", 1'b0, 2'd0, 1'b0);
    RST_N = 1'b1;
    step(3);
    expect_after(0, "idle_after_reset", 1'b0, 2'd0, 1'b0);

    // Clean press of colour 2
    BTN = 4'b0100;
    expect_after(5, "clean_before_edge5", 1'b0, 2'd0, 1'b0);
    expect_after(1, "clean_edge5", 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 14; i++) expect_after(1, "clean_hold", 1'b1, 2'd2, 1'b0);
    BTN = 4'b0000;
    expect_after(5, "clean_rel_before", 1'b1, 2'd2, 1'b0);
    expect_after(1, "clean_rel_edge5", 1'b0, 2'd2, 1'b0);
    step(3);

    // Press bounce on colour 1: ends high after the 10th toggle
    BTN = 4'b0010;
    for (int i = 0; i < 2; i++) expect_after(1, "bounce_press", 1'b0, 2'd2, 1'b0);
    for (int t = 0; t < 9; t++) begin
      BTN[1] = ~BTN[1];
      for (int i = 0; i < 2; i++) expect_after(1, "bounce_press", 1'b0, 2'd2, 1'b0);
    end
    BTN[1] = ~BTN[1];
    expect_after(5, "bounce_before", 1'b0, 2'd2, 1'b0);
    expect_after(1, "bounce_edge5", 1'b1, 2'd1, 1'b0);
    BTN = 4'b0000;
    expect_after(6, "bounce_release", 1'b0, 2'd1, 1'b0);

    // Release bounce on colour 3
    BTN = 4'b1000;
    expect_after(6, "relb_press", 1'b1, 2'd3, 1'b0);
    BTN = 4'b0000;
    expect_after(2, "relb_drop", 1'b1, 2'd3, 1'b0);
    BTN = 4'b1000;
    for (int i = 0; i < 8; i++) expect_after(1, "relb_hold", 1'b1, 2'd3, 1'b0);
    BTN = 4'b0000;
    expect_after(5, "relb_full_before", 1'b1, 2'd3, 1'b0);
    expect_after(1, "relb_full_edge5", 1'b0, 2'd3, 1'b0);

    // Multi-press rejection, then single press, then extra button ignored
    BTN = 4'b0011;
    for (int i = 0; i < 10; i++) expect_after(1, "multi_reject", 1'b0, 2'd3, 1'b0);
    BTN = 4'b0010;
    expect_after(5, "multi_single_before", 1'b0, 2'd3, 1'b0);
    expect_after(1, "multi_single_edge5", 1'b1, 2'd1, 1'b0);
    BTN = 4'b1010;
    for (int i = 0; i < 10; i++) expect_after(1, "multi_extra", 1'b1, 2'd1, 1'b0);
    BTN = 4'b0000;
    expect_after(6, "multi_release", 1'b0, 2'd1, 1'b0);

    // Start channel: short glitch, then a full hold and release
    BTN_START = 1'b1;
    step(3);
    BTN_START = 1'b0;
    for (int i = 0; i < 10; i++) expect_after(1, "start_glitch", 1'b0, 2'd1, 1'b0);
    BTN_START = 1'b1;
    expect_after(5, "start_before", 1'b0, 2'd1, 1'b0);
    expect_after(1, "start_edge5", 1'b0, 2'd1, 1'b1);
    step(4);
    BTN_START = 1'b0;
    expect_after(5, "start_rel_before", 1'b0, 2'd1, 1'b1);
    expect_after(1, "start_rel_edge5", 1'b0, 2'd1, 1'b0);
    step(3);

    // Reset while pressed, button and start still held afterwards
    BTN       = 4'b0100;
    BTN_START = 1'b1;
    expect_after(5, "rst_pre_before", 1'b0, 2'd1, 1'b0);
    expect_after(1, "rst_pre_edge5", 1'b1, 2'd2, 1'b1);
    RST_N = 1'b0;
    #1;
    expect_after(0, "rst_async", 1'b0, 2'd0, 1'b0);
    step(2);
    expect_after(0, "rst_held", 1'b0, 2'd0, 1'b0);
    RST_N = 1'b1;
    expect_after(5, "rst_repress_before", 1'b0, 2'd0, 1'b0);
    expect_after(1, "rst_repress_edge5", 1'b1, 2'd2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
